// File: rtl/dcache_2way_top.sv
`default_nettype none
// ============================================================================
// Module   : dcache_2way_top
// Brief    : 2-way set-associative write-back/write-allocate L1 data cache
//            with per-set LRU and a whole-cache flush/invalidate sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_2way_top #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic              flush_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BSEL_W = $clog2(WORD_W / 8);
    localparam int WSEL_W = OFF_W - BSEL_W;
    localparam int WBIT_W = $clog2(WORD_W);
    localparam int LBIT_W = WSEL_W + WBIT_W;
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = '1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_REFILL     = 3'd3,
        S_REFILLOK   = 3'd4,
        S_FLUSH_SCAN = 3'd5,
        S_FLUSH_WB   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [TAG_W-1:0]  r_tag   [2][SETS];
    logic [LINE_W-1:0] r_data  [2][SETS];
    logic [SETS-1:0]   r_valid [2];
    logic [SETS-1:0]   r_dirty [2];
    logic [SETS-1:0]   r_lru;
    logic              r_victim;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic              r_flush_done;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WSEL_W-1:0] w_wsel;
    logic [LBIT_W-1:0] w_bitoff;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hitway;
    logic              w_req;
    logic              w_idle_ok;
    logic              w_victim;
    logic              w_vic_dirty;
    logic [IDX_W-1:0]  w_fset;
    logic              w_fway;
    logic              w_f_dirty;
    logic              w_f_last;
    logic              w_flush_exit;
    logic [LINE_W-1:0] w_hit_line;
    logic              w_unused_ok;

    assign w_tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx    = p1_addr_i[OFF_W +: IDX_W];
    assign w_wsel   = p1_addr_i[BSEL_W +: WSEL_W];
    assign w_bitoff = {w_wsel, {WBIT_W{1'b0}}};
    assign w_unused_ok = ^p1_addr_i[BSEL_W-1:0];

    assign w_hit0    = r_valid[0][w_idx] & (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] & (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hitway  = w_hit1;
    assign w_req     = p1_MemRead_i | p1_MemWrite_i;
    assign w_idle_ok = (r_state == S_IDLE) & w_hit & ~flush_i;

    assign w_hit_line = r_data[w_hitway][w_idx];
    assign p1_data_o  = w_hit ? w_hit_line[w_bitoff +: WORD_W] : '0;
    assign p1_stall_o = w_req & ~w_idle_ok;

    // Fill invalid ways first (way 0 preferred), otherwise evict the LRU way
    assign w_victim    = ~r_valid[0][w_idx] ? 1'b0 :
                         ~r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_vic_dirty = r_valid[r_victim][w_idx] & r_dirty[r_victim][w_idx];

    assign w_fset    = r_cnt[IDX_W:1];
    assign w_fway    = r_cnt[0];
    assign w_f_dirty = r_valid[w_fway][w_fset] & r_dirty[w_fway][w_fset];
    assign w_f_last  = (r_cnt == c_cnt_last);

    always_comb begin
        w_next_state = r_state;
        w_flush_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush_i)
                    w_next_state = S_FLUSH_SCAN;
                else if (w_req & ~w_hit)
                    w_next_state = S_MISS;
            end
            S_MISS:      w_next_state = w_vic_dirty ? S_WRITEBACK : S_REFILL;
            S_WRITEBACK: if (mem_ack_i) w_next_state = S_REFILL;
            S_REFILL:    if (mem_ack_i) w_next_state = S_REFILLOK;
            S_REFILLOK:  w_next_state = S_IDLE;
            S_FLUSH_SCAN: begin
                if (w_f_dirty) begin
                    w_next_state = S_FLUSH_WB;
                end else if (w_f_last) begin
                    w_next_state = S_IDLE;
                    w_flush_exit = 1'b1;
                end
            end
            S_FLUSH_WB: begin
                if (mem_ack_i) begin
                    w_next_state = w_f_last ? S_IDLE : S_FLUSH_SCAN;
                    w_flush_exit = w_f_last;
                end
            end
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_dirty[0]   <= '0;
            r_dirty[1]   <= '0;
            r_lru        <= '0;
            r_victim     <= 1'b0;
            r_cnt        <= '0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= w_flush_exit;
            case (r_state)
                S_IDLE: begin
                    if (w_idle_ok & w_req) begin
                        r_lru[w_idx] <= ~w_hitway;
                        if (p1_MemWrite_i)
                            r_dirty[w_hitway][w_idx] <= 1'b1;
                    end
                    if (w_next_state == S_MISS)
                        r_victim <= w_victim;
                end
                S_MISS: begin
                    r_mem_enable <= 1'b1;
                    r_mem_write  <= w_vic_dirty;
                end
                S_WRITEBACK: begin
                    if (mem_ack_i)
                        r_mem_write <= 1'b0;
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_lru[w_idx]             <= ~r_victim;
                        r_mem_enable             <= 1'b0;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (w_f_dirty) begin
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= 1'b1;
                    end else begin
                        r_valid[w_fway][w_fset] <= 1'b0;
                        r_cnt                   <= r_cnt + 1'b1;
                    end
                end
                S_FLUSH_WB: begin
                    if (mem_ack_i) begin
                        r_valid[w_fway][w_fset] <= 1'b0;
                        r_dirty[w_fway][w_fset] <= 1'b0;
                        r_mem_enable            <= 1'b0;
                        r_mem_write             <= 1'b0;
                        r_cnt                   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_flush_exit) begin
                r_cnt <= '0;
                r_lru <= '0;
            end
        end
    end

    // Payload arrays carry no reset; validity alone decides whether they are used
    always_ff @(posedge clk_i) begin
        if (w_idle_ok & p1_MemWrite_i)
            r_data[w_hitway][w_idx][w_bitoff +: WORD_W] <= p1_data_i;
        if ((r_state == S_REFILL) & mem_ack_i) begin
            r_data[r_victim][w_idx] <= mem_data_i;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

    always_comb begin
        mem_addr_o = {w_tag, w_idx, {OFF_W{1'b0}}};
        mem_data_o = r_data[r_victim][w_idx];
        if (r_state == S_WRITEBACK) begin
            mem_addr_o = {r_tag[r_victim][w_idx], w_idx, {OFF_W{1'b0}}};
        end else if ((r_state == S_FLUSH_SCAN) || (r_state == S_FLUSH_WB)) begin
            mem_addr_o = {r_tag[w_fway][w_fset], w_fset, {OFF_W{1'b0}}};
            mem_data_o = r_data[w_fway][w_fset];
        end
    end

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign flush_busy_o = (r_state == S_FLUSH_SCAN) || (r_state == S_FLUSH_WB);
    assign flush_done_o = r_flush_done;

endmodule
`default_nettype wire

// File: tb/tb_dcache_2way_top.sv
`default_nettype none
// Directed bench for dcache_2way_top: a line-wide backing memory with fixed
// latency answers refills/write-backs; each task checks one scenario inline.
module tb_dcache_2way_top;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  p1_data;
    logic [31:0]  p1_addr;
    logic         p1_rd;
    logic         p1_wr;
    logic [31:0]  p1_q;
    logic         p1_stall;
    logic         flush;
    logic         flush_busy;
    logic         flush_done;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_en;
    logic         mem_we;

    int errors = 0;
    int checks = 0;

    logic         mem_hold;
    int           lat;
    int           en_cycles;
    logic [31:0]  log_addr[$];
    logic         log_we[$];
    logic [255:0] log_line[$];
    logic [255:0] backing [logic [31:0]];

    always #5 clk = ~clk;

    dcache_2way_top dut (
        .clk_i(clk), .rst_i(rst_n),
        .p1_data_i(p1_data), .p1_addr_i(p1_addr),
        .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
        .p1_data_o(p1_q), .p1_stall_o(p1_stall),
        .flush_i(flush), .flush_busy_o(flush_busy), .flush_done_o(flush_done),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .mem_data_o(mem_wdata), .mem_addr_o(mem_addr),
        .mem_enable_o(mem_en), .mem_write_o(mem_we)
    );

    // Untouched lines: word k = k | ((addr >> 8) << 16)
    function automatic logic [255:0] default_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  hi;
        hi = (a >> 8) << 16;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'(k) | hi;
        return l;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            lat     <= 0;
            mem_ack <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_en) en_cycles <= en_cycles + 1;
            if (mem_en && !mem_ack && !mem_hold) begin
                if (lat == 2) begin
                    lat     <= 0;
                    mem_ack <= 1'b1;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    log_line.push_back(mem_wdata);
                    if (mem_we)
                        backing[mem_addr] = mem_wdata;
                    else
                        mem_rdata <= backing.exists(mem_addr) ? backing[mem_addr] : default_line(mem_addr);
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q, output int cyc);
        @(negedge clk);
        p1_addr = a; p1_data = d; p1_rd = !wr; p1_wr = wr;
        cyc = 0;
        #1;
        while (p1_stall && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles, required < 100", a, cyc);
        end
        q = p1_q;
        @(posedge clk); #1;
        p1_rd = 1'b0; p1_wr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b required 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", flush_busy); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", flush_done); end
        checks++; if (p1_stall !== 1'b0) begin errors++; $display("FAIL rst_stall_idle: got %b required 0", p1_stall); end
    endtask

    task automatic test_cold_refill();
        logic [31:0] q; int cyc; int n0;
        n0 = log_addr.size();
        access(1'b0, 32'h40, 32'h0, q, cyc);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL cold_data: got %h required 0", q); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL cold_stall_cycles: got %0d required 7", cyc); end
        checks++; if (log_addr.size() !== n0 + 1) begin errors++; $display("FAIL cold_txn_count: got %0d required %0d", log_addr.size() - n0, 1); end
        else begin
            checks++; if (log_addr[n0] !== 32'h40 || log_we[n0] !== 1'b0) begin errors++; $display("FAIL cold_txn: got addr %h we %b required 40/0", log_addr[n0], log_we[n0]); end
        end
        access(1'b0, 32'h44, 32'h0, q, cyc);
        checks++; if (q !== 32'h1 || cyc !== 0) begin errors++; $display("FAIL hit_next_word: got %h stall %0d required 1 stall 0", q, cyc); end
    endtask

    task automatic test_lru();
        logic [31:0] q; int cyc; int n0;
        access(1'b0, 32'h000, 32'h0, q, cyc);
        access(1'b0, 32'h200, 32'h0, q, cyc);
        access(1'b0, 32'h000, 32'h0, q, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL lru_a_hit: got stall %0d required 0", cyc); end
        n0 = log_addr.size();
        access(1'b0, 32'h400, 32'h0, q, cyc);
        checks++; if (log_addr.size() !== n0 + 1 || log_addr[n0] !== 32'h400 || log_we[n0] !== 1'b0)
            begin errors++; $display("FAIL lru_c_refill: got %0d txns required one refill of 400", log_addr.size() - n0); end
        checks++; if (q !== 32'h0004_0000) begin errors++; $display("FAIL lru_c_data: got %h required 00040000", q); end
        access(1'b0, 32'h004, 32'h0, q, cyc);
        checks++; if (cyc !== 0 || q !== 32'h1) begin errors++; $display("FAIL lru_a_kept: got %h stall %0d required 1 stall 0", q, cyc); end
        n0 = log_addr.size();
        access(1'b0, 32'h204, 32'h0, q, cyc);
        checks++; if (log_addr.size() !== n0 + 1 || q !== 32'h0002_0001)
            begin errors++; $display("FAIL lru_b_evicted: got %0d txns data %h required 1 txn data 00020001", log_addr.size() - n0, q); end
    endtask

    task automatic test_writeback();
        logic [31:0] q; int cyc; int n0;
        access(1'b1, 32'h200, 32'hDEADBEEF, q, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL wb_store_hit: got stall %0d required 0", cyc); end
        access(1'b0, 32'h400, 32'h0, q, cyc);
        n0 = log_addr.size();
        access(1'b0, 32'h600, 32'h0, q, cyc);
        checks++; if (log_addr.size() !== n0 + 2) begin errors++; $display("FAIL wb_txn_count: got %0d required 2", log_addr.size() - n0); end
        else begin
            checks++; if (log_addr[n0] !== 32'h200 || log_we[n0] !== 1'b1 || log_line[n0][31:0] !== 32'hDEADBEEF || log_line[n0][63:32] !== 32'h0002_0001)
                begin errors++; $display("FAIL wb_line: got addr %h we %b w0 %h w1 %h required 200/1/deadbeef/00020001", log_addr[n0], log_we[n0], log_line[n0][31:0], log_line[n0][63:32]); end
            checks++; if (log_addr[n0+1] !== 32'h600 || log_we[n0+1] !== 1'b0)
                begin errors++; $display("FAIL wb_then_refill: got addr %h we %b required 600/0", log_addr[n0+1], log_we[n0+1]); end
        end
        checks++; if (q !== 32'h0006_0000) begin errors++; $display("FAIL wb_refill_data: got %h required 00060000", q); end
        access(1'b0, 32'h200, 32'h0, q, cyc);
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_reload: got %h required deadbeef", q); end
    endtask

    task automatic test_store_word();
        logic [31:0] q; int cyc; int e0; int n0;
        logic [31:0] exp;
        access(1'b0, 32'h000, 32'h0, q, cyc);
        e0 = en_cycles; n0 = log_addr.size();
        access(1'b1, 32'h010, 32'hCAFEF00D, q, cyc);
        for (int k = 0; k < 8; k++) begin
            access(1'b0, 32'(k * 4), 32'h0, q, cyc);
            exp = (k == 4) ? 32'hCAFEF00D : 32'(k);
            checks++; if (q !== exp || cyc !== 0) begin errors++; $display("FAIL store_word%0d: got %h stall %0d required %h stall 0", k, q, cyc, exp); end
        end
        checks++; if (en_cycles !== e0 || log_addr.size() !== n0) begin errors++; $display("FAIL store_no_mem: got %0d enable cycles required 0", en_cycles - e0); end
    endtask

    task automatic test_flush();
        logic [31:0] q; int cyc; int n0; int dones; int n;
        access(1'b1, 32'h1E0, 32'h12345678, q, cyc);
        n0 = log_addr.size();
        @(negedge clk); flush = 1'b1;
        n = 0;
        while (!flush_busy && n < 20) begin @(negedge clk); n++; end
        flush = 1'b0;
        checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b required 1", flush_busy); end
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (flush_done) dones++;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL flush_done_pulses: got %0d required 1", dones); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_end: got %b required 0", flush_busy); end
        checks++; if (log_addr.size() !== n0 + 2) begin errors++; $display("FAIL flush_wb_count: got %0d required 2", log_addr.size() - n0); end
        else begin
            checks++; if (log_addr[n0] !== 32'h000 || log_we[n0] !== 1'b1 || log_line[n0][159:128] !== 32'hCAFEF00D)
                begin errors++; $display("FAIL flush_wb0: got addr %h we %b w4 %h required 000/1/cafef00d", log_addr[n0], log_we[n0], log_line[n0][159:128]); end
            checks++; if (log_addr[n0+1] !== 32'h1E0 || log_we[n0+1] !== 1'b1 || log_line[n0+1][31:0] !== 32'h12345678)
                begin errors++; $display("FAIL flush_wb1: got addr %h we %b w0 %h required 1e0/1/12345678", log_addr[n0+1], log_we[n0+1], log_line[n0+1][31:0]); end
        end
        access(1'b0, 32'h010, 32'h0, q, cyc);
        checks++; if (cyc == 0 || q !== 32'hCAFEF00D) begin errors++; $display("FAIL flush_reload_a: got %h stall %0d required cafef00d after miss", q, cyc); end
        access(1'b0, 32'h040, 32'h0, q, cyc);
        checks++; if (cyc == 0) begin errors++; $display("FAIL flush_invalidated: got stall %0d required miss", cyc); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] q; int cyc; int n;
        mem_hold = 1'b1;
        @(negedge clk); p1_addr = 32'h80; p1_rd = 1'b1;
        n = 0;
        while (!mem_en && n < 20) begin @(negedge clk); n++; end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0)
            begin errors++; $display("FAIL mid_refill_req: got en %b addr %h we %b required 1/80/0", mem_en, mem_addr, mem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_reset_en: got %b required 0", mem_en); end
        checks++; if (p1_stall !== 1'b1) begin errors++; $display("FAIL mid_reset_stall: got %b required 1", p1_stall); end
        @(negedge clk);
        rst_n = 1'b1; p1_rd = 1'b0; mem_hold = 1'b0;
        access(1'b0, 32'h80, 32'h0, q, cyc);
        checks++; if (cyc == 0 || q !== 32'h0) begin errors++; $display("FAIL post_reset_80: got %h stall %0d required 0 after miss", q, cyc); end
        access(1'b0, 32'h010, 32'h0, q, cyc);
        checks++; if (cyc == 0) begin errors++; $display("FAIL post_reset_invalid: got stall %0d required miss", cyc); end
    endtask

    initial begin
        rst_n = 1'b0; p1_data = '0; p1_addr = '0; p1_rd = 1'b0; p1_wr = 1'b0;
        flush = 1'b0; mem_hold = 1'b0; en_cycles = 0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        test_reset();
        test_cold_refill();
        test_lru();
        test_writeback();
        test_store_word();
        test_flush();
        test_reset_mid_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
- Parametrised successor to the single-way L1 data cache: 2-way set-associative, write-back, write-allocate.
- Per-set LRU replacement and a whole-cache flush/invalidate sequencer.
- Sits between the CPU MEM stage (p1_* interface) and the line-wide data memory (mem_* interface).
- Tag, valid, dirty, LRU and data storage are internal flop arrays; no external SRAM macros.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, CPU data width.
- LINE_W, 256, line width in bits; power of two, multiple of WORD_W.
- SETS, 16, number of sets; power of two, ≥2.
- Derived: OFF_W = log2(LINE_W/8), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- p1_data_i  in  WORD_W  CPU store data.
- p1_addr_i  in  ADDR_W  CPU byte address, word-aligned.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; never asserted together with p1_MemRead_i.
- p1_data_o  out  WORD_W  load data, combinational.
- p1_stall_o  out  1  CPU must hold request and pipeline.
- flush_i  in  1  request write-back of all dirty lines, then invalidate all lines.
- flush_busy_o  out  1  flush in progress.
- flush_done_o  out  1  one-cycle pulse when flush completes.
- mem_data_i  in  LINE_W  refill line.
- mem_ack_i  in  1  memory completes the current request; one-cycle pulse.
- mem_data_o  out  LINE_W  write-back line.
- mem_addr_o  out  ADDR_W  line address, low OFF_W bits zero.
- mem_enable_o  out  1  memory request valid; registered.
- mem_write_o  out  1  1 = write-back, 0 = refill; registered.

Behaviour:
- Address split: offset = addr[OFF_W-1:0]; index = addr[OFF_W+IDX_W-1:OFF_W]; tag = remaining upper bits. Word select = offset[OFF_W-1:2].
- Reset (async, rst_i=0):
  - All valid, dirty and LRU bits cleared; state IDLE; flush counter 0.
  - mem_enable_o=0, mem_write_o=0, flush_busy_o=0, flush_done_o=0.
  - Data and tag arrays are not reset.
- Lookup (combinational, same cycle): hit_w = valid[w][idx] & tag[w][idx]==p1 tag, for w=0,1. hit = hit_w0 | hit_w1; both hitting is illegal and cannot arise.
- p1_req = p1_MemRead_i | p1_MemWrite_i.
- p1_stall_o = p1_req & ~(state==IDLE & hit & ~flush_i).
- p1_data_o: selected word of the hitting way when hit; 0 otherwise.
- Read hit (IDLE): zero-latency; at clock edge lru[idx] <= ~hitway.
- Write hit (IDLE): at clock edge the selected word of the hitting way <= p1_data_i; dirty set; lru[idx] <= ~hitway. Other words are unchanged.
- Victim selection: latched at IDLE->MISS as follows.
  - Way 0 if invalid.
  - Otherwise way 1 if invalid.
  - Otherwise lru[idx] (0 means way 0 is least recently used).
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILLOK, FLUSH_SCAN, FLUSH_WB.
  - IDLE: flush_i=1 -> FLUSH_SCAN (flush has priority over p1_req). Otherwise p1_req & ~hit -> MISS.
  - MISS: latch victim. If victim valid & dirty -> WRITEBACK with mem_enable=1, mem_write=1. Otherwise -> REFILL with mem_enable=1, mem_write=0.
  - WRITEBACK: mem_addr_o = {victim tag, idx, 0}; mem_data_o = victim line. On mem_ack_i: mem_write<=0, mem_enable stays 1 -> REFILL.
  - REFILL: mem_addr_o = {p1 tag, idx, 0}. On mem_ack_i: victim line <= mem_data_i, tag <= p1 tag, valid=1, dirty=0, lru[idx] <= ~victim, mem_enable<=0 -> REFILLOK.
  - REFILLOK: one cycle -> IDLE. The held request then hits and completes in IDLE; a store is merged there as a write hit.
  - FLUSH_SCAN: counter c walks over set = c[IDX_W:1], way = c[0]. If the entry is valid & dirty -> FLUSH_WB with mem_enable=1, mem_write=1. Otherwise clear valid, then either increment c or, at the last entry (2*SETS-1), go to IDLE.
  - FLUSH_WB: write back entry c; on mem_ack_i clear valid/dirty, mem_enable<=0, return to FLUSH_SCAN with c+1; if the entry was the last one, go to IDLE instead.
  - On flush exit: flush_done_o pulses for exactly one cycle, c resets to 0, and all LRU bits are cleared.
- flush_busy_o = 1 in FLUSH_SCAN and FLUSH_WB.
- flush_i is ignored outside IDLE; it is held by the requester until busy is seen.
- mem_addr_o and mem_data_o are don't-care when mem_enable_o=0.
- Reset asserted mid-transaction aborts immediately. All lines are invalid afterwards; the in-flight memory request is abandoned.

Test Plan:
- Cold load 0x0000_0040 with memory returning line word k = k -> one REFILL (addr 0x40, write=0). Stall deasserts the cycle after REFILLOK; p1_data_o=0 (word 0). A load of 0x44 next cycle returns 1 with no stall.
- Tags A=0x000, B=0x200, C=0x400 in set 0: load A, load B, load A, load C -> C evicts B (LRU), not A. A reload of A hits; a reload of B misses.
- Store 0xDEADBEEF to 0x200, then load 0x400 and 0x600 -> second miss issues WRITEBACK addr 0x200 with word 0 = 0xDEADBEEF before REFILL addr 0x600.
- Dirty lines in sets 0 and 15, then flush_i -> exactly two write-backs in ascending set order. flush_done_o pulses once. All subsequent loads miss.
- Store hit to 0x10 -> only word 4 changes; no mem_enable_o activity.
- rst_i low during REFILL -> mem_enable_o=0 immediately; state IDLE; a reload of the same address misses.
